// File: rtl/gpio_timer_pkg.sv
// ============================================================================
//  gpio_timer_pkg
//  Register offsets, CTRL bit positions and mode encodings for the timer bank.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gpio_timer_pkg;

    localparam logic [3:0] c_OFF_CTRL   = 4'h0;
    localparam logic [3:0] c_OFF_STATUS = 4'h1;
    localparam logic [3:0] c_OFF_PRE_LO = 4'h2;
    localparam logic [3:0] c_OFF_PRE_HI = 4'h3;
    localparam logic [3:0] c_OFF_CNT    = 4'h4;
    localparam logic [3:0] c_OFF_TOP    = 4'h8;
    localparam logic [3:0] c_OFF_CMP    = 4'hC;

    localparam int c_CTRL_EN   = 0;
    localparam int c_CTRL_MODE = 1;
    localparam int c_CTRL_EXT  = 3;
    localparam int c_CTRL_IE   = 4;
    localparam int c_CTRL_INV  = 5;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PWM      = 2'b10
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/gpio_timer_ch.sv
// ============================================================================
//  gpio_timer_ch
//  One timer/PWM channel: registers, ext-clock synchroniser, prescaler,
//  counter and output stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_timer_ch
    import gpio_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [3:0] off_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    input  logic       re_i,
    input  logic       ext_clk_i,
    output logic [7:0] rdata_o,
    output logic       tmr_o,
    output logic       irq_o
);
    localparam int BYTES = WIDTH / 8;

    logic [5:0]       ctrl_q;
    logic             flag_q;
    logic             lvl_q;
    logic [1:0]       sync_q;
    logic             edge_q;
    logic [15:0]      pre_q;
    logic [15:0]      pc_q;
    logic [23:0]      stage_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] cmp_q;
    logic [WIDTH-1:0] snap_q;

    logic             w_en;
    logic             w_pwm;
    logic             w_oneshot;
    logic             w_tick;
    logic             w_step;
    logic             w_wrap;
    logic             w_level;
    logic [16:0]      w_pre_eff;
    logic [16:0]      w_pc_inc;
    logic [1:0]       w_k;
    logic [1:0]       w_field;
    logic             w_multi_wr;
    logic             w_stage_en;
    logic             w_commit_en;
    logic             w_cnt_wr;
    logic [WIDTH-1:0] w_commit;
    logic [31:0]      w_snap32;
    logic [31:0]      w_top32;
    logic [31:0]      w_cmp32;
    logic             w_unused;

    assign w_en      = ctrl_q[c_CTRL_EN];
    assign w_pwm     = (ctrl_q[c_CTRL_MODE +: 2] == MODE_PWM);
    assign w_oneshot = (ctrl_q[c_CTRL_MODE +: 2] == MODE_ONESHOT);
    assign w_tick    = w_en & (ctrl_q[c_CTRL_EXT] ? (sync_q[1] & ~edge_q) : 1'b1);
    assign w_pre_eff = (pre_q == 16'd0) ? 17'd1 : {1'b0, pre_q};
    assign w_pc_inc  = {1'b0, pc_q} + 17'd1;
    assign w_step    = w_tick & (w_pc_inc >= w_pre_eff);

    // CNT/TOP/CMP share one decode: offset[3:2] picks the field, [1:0] the byte
    assign w_k         = off_i[1:0];
    assign w_field     = off_i[3:2];
    assign w_multi_wr  = we_i & (w_field != 2'b00) & (int'(w_k) < BYTES);
    assign w_stage_en  = w_multi_wr & (int'(w_k) < BYTES - 1);
    assign w_commit_en = w_multi_wr & (int'(w_k) == BYTES - 1);
    assign w_cnt_wr    = w_commit_en & (w_field == c_OFF_CNT[3:2]);

    // A CNT commit overrides the step in the same cycle, so no wrap is taken
    assign w_wrap  = w_step & ~w_cnt_wr & (cnt_q >= top_q);
    assign w_level = w_pwm ? (cnt_q < cmp_q) : lvl_q;
    assign tmr_o   = w_level ^ ctrl_q[c_CTRL_INV];
    assign irq_o   = flag_q & ctrl_q[c_CTRL_IE];

    always_comb begin
        w_commit = WIDTH'(stage_q);
        w_commit[WIDTH-8 +: 8] = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
            lvl_q   <= 1'b0;
            sync_q  <= '0;
            edge_q  <= 1'b0;
            pre_q   <= '0;
            pc_q    <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
            top_q   <= '1;
            cmp_q   <= '0;
            snap_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], ext_clk_i};
            edge_q <= sync_q[1];

            if (!w_en) begin
                pc_q <= '0;
            end else if (w_tick) begin
                pc_q <= w_step ? 16'd0 : w_pc_inc[15:0];
            end

            if (w_cnt_wr) begin
                cnt_q <= w_commit;
            end else if (w_step) begin
                cnt_q <= (cnt_q >= top_q) ? '0 : cnt_q + WIDTH'(1);
            end

            if (w_wrap && !w_pwm) begin
                lvl_q <= ~lvl_q;
            end

            if (w_wrap) begin
                flag_q <= 1'b1;
            end else if (we_i && off_i == c_OFF_STATUS && wdata_i[0]) begin
                flag_q <= 1'b0;
            end

            if (we_i && off_i == c_OFF_CTRL) begin
                ctrl_q <= wdata_i[5:0];
            end else if (w_wrap && w_oneshot) begin
                ctrl_q[c_CTRL_EN] <= 1'b0;
            end

            if (we_i && off_i == c_OFF_PRE_LO) begin
                stage_q[7:0] <= wdata_i;
            end
            if (w_stage_en) begin
                stage_q[8*w_k +: 8] <= wdata_i;
            end
            if (we_i && off_i == c_OFF_PRE_HI) begin
                pre_q <= {wdata_i, stage_q[7:0]};
            end
            if (w_commit_en && w_field == c_OFF_TOP[3:2]) begin
                top_q <= w_commit;
            end
            if (w_commit_en && w_field == c_OFF_CMP[3:2]) begin
                cmp_q <= w_commit;
            end

            if (re_i && off_i == c_OFF_CNT) begin
                snap_q <= cnt_q;
            end
        end
    end

    assign w_snap32 = 32'(snap_q);
    assign w_top32  = 32'(top_q);
    assign w_cmp32  = 32'(cmp_q);

    always_comb begin
        rdata_o = '0;
        case (off_i)
            c_OFF_CTRL:   rdata_o = {2'b00, ctrl_q};
            c_OFF_STATUS: rdata_o = {5'b00000, w_level, w_en, flag_q};
            c_OFF_PRE_LO: rdata_o = pre_q[7:0];
            c_OFF_PRE_HI: rdata_o = pre_q[15:8];
            default: begin
                if (int'(w_k) < BYTES) begin
                    if (w_field == c_OFF_CNT[3:2]) begin
                        rdata_o = (w_k == 2'd0) ? cnt_q[7:0] : w_snap32[8*w_k +: 8];
                    end else if (w_field == c_OFF_TOP[3:2]) begin
                        rdata_o = w_top32[8*w_k +: 8];
                    end else begin
                        rdata_o = w_cmp32[8*w_k +: 8];
                    end
                end
            end
        endcase
    end

    assign w_unused = ^{wdata_i[7:6], stage_q};

endmodule

`default_nettype wire

// File: rtl/gpio_timer_bank.sv
// ============================================================================
//  gpio_timer_bank
//  NUM_CH timer/PWM channels behind the 8-bit register bus, with read mux and
//  interrupt reduction.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_timer_bank
    import gpio_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 16,
    localparam int ADDR_W = $clog2(NUM_CH) + 4
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    input  logic              we_i,
    input  logic              re_i,
    output logic [7:0]        rdata_o,
    input  logic [NUM_CH-1:0] ext_clk_i,
    output logic [NUM_CH-1:0] tmr_o,
    output logic [NUM_CH-1:0] irq_vec_o,
    output logic              irq_o
);
    logic [ADDR_W-1:0] w_ch_sel;
    logic [NUM_CH-1:0] w_hit;
    logic [7:0]        w_ch_rdata [NUM_CH];

    // Channel indices past NUM_CH match no channel and read 0
    assign w_ch_sel = addr_i >> 4;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_hit[i] = (w_ch_sel == ADDR_W'(i));

        gpio_timer_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk_i     (clk_i),
            .rst       (rst),
            .off_i     (addr_i[3:0]),
            .wdata_i   (wdata_i),
            .we_i      (we_i & w_hit[i]),
            .re_i      (re_i & w_hit[i]),
            .ext_clk_i (ext_clk_i[i]),
            .rdata_o   (w_ch_rdata[i]),
            .tmr_o     (tmr_o[i]),
            .irq_o     (irq_vec_o[i])
        );
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_hit[i]) begin
                rdata_o = w_ch_rdata[i];
            end
        end
    end

    assign irq_o = |irq_vec_o;

endmodule

`default_nettype wire

// File: tb/tb_gpio_timer_bank.sv
// ============================================================================
//  tb_gpio_timer_bank
//  Randomised self-checking bench; expectations come from closed-form timer
//  arithmetic (steps = cycles / prescale, count = steps mod period).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpio_timer_bank;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = $clog2(NUM_CH) + 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              we;
    logic              re;
    logic [7:0]        rdata;
    logic [NUM_CH-1:0] ext;
    logic [NUM_CH-1:0] tmr;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    int n_checks;
    int n_fail;

    gpio_timer_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk_i     (clk),
        .rst       (rst),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .we_i      (we),
        .re_i      (re),
        .rdata_o   (rdata),
        .ext_clk_i (ext),
        .tmr_o     (tmr),
        .irq_vec_o (irq_vec),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int ch, input int off, input int d);
        addr  = ADDR_W'(ch * 16 + off);
        wdata = 8'(d);
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic peek(input int ch, input int off, output logic [7:0] d);
        addr = ADDR_W'(ch * 16 + off);
        #1;
        d = rdata;
    endtask

    task automatic rd_re(input int ch, input int off, output logic [7:0] d);
        addr = ADDR_W'(ch * 16 + off);
        re   = 1'b1;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        re   = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int pre, per, t, n, s, wraps, inv, lvl0, held, kw, hi, lo, cnt_hi;
        int cmp_tab [5];
        int inv_tab [5];

        n_checks = 0;
        n_fail   = 0;
        lvl0     = 0;
        held     = 0;
        rst   = 1'b1;
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;
        ext   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_val("rst_tmr", 32'(tmr), 0);
        check_val("rst_irq", 32'(irq), 0);
        check_val("rst_irqvec", 32'(irq_vec), 0);
        peek(0, 0, d);  check_val("rst_ctrl", 32'(d), 0);
        peek(0, 1, d);  check_val("rst_status", 32'(d), 0);
        peek(0, 8, d);  check_val("rst_top_lo", 32'(d), 32'hFF);
        peek(0, 9, d);  check_val("rst_top_hi", 32'(d), 32'hFF);
        peek(2, 12, d); check_val("rst_cmp_lo", 32'(d), 0);
        peek(1, 6, d);  check_val("rst_cnt_b2", 32'(d), 0);

        // Periodic mode on ch0 with random prescale / period / invert
        for (int it = 0; it < 3; it++) begin
            pre = $urandom_range(0, 3);
            t   = $urandom_range(0, 6);
            inv = $urandom_range(0, 1);
            per = (pre == 0) ? 1 : pre;
            n   = per * (t + 1) * 2 + $urandom_range(0, 5);
            wr(0, 1, 1);
            wr(0, 4, 0);
            wr(0, 5, 0);
            wr(0, 2, pre);
            wr(0, 3, 0);
            wr(0, 8, t);
            wr(0, 9, 0);
            wr(0, 0, 32'h11 | (inv << 5));
            for (int k = 1; k <= n; k++) begin
                tick();
                s     = k / per;
                wraps = s / (t + 1);
                peek(0, 4, d);
                check_val("per_cnt", 32'(d), s % (t + 1));
                check_val("per_tmr", 32'(tmr[0]), lvl0 ^ (wraps & 1) ^ inv);
                check_val("per_irq", 32'(irq), (wraps > 0) ? 1 : 0);
            end
            wr(0, 0, 32'h10 | (inv << 5));
            s     = (n + 1) / per;
            wraps = s / (t + 1);
            lvl0  = lvl0 ^ (wraps & 1);
            held  = s % (t + 1);
            tick();
            tick();
            peek(0, 4, d);
            check_val("hold_cnt", 32'(d), held);
            check_val("hold_tmr", 32'(tmr[0]), lvl0 ^ inv);
            check_val("hold_irq", 32'(irq), (wraps > 0) ? 1 : 0);
            wr(0, 1, 1);
            check_val("w1c_irq", 32'(irq), 0);
            check_val("w1c_irqvec", 32'(irq_vec), 0);
        end

        // One-shot on ch1
        pre = $urandom_range(0, 3);
        t   = $urandom_range(0, 2);
        per = (pre == 0) ? 1 : pre;
        kw  = per * (t + 1);
        wr(1, 2, pre);
        wr(1, 3, 0);
        wr(1, 8, t);
        wr(1, 9, 0);
        wr(1, 0, 32'h03);
        for (int k = 1; k <= kw + 4; k++) begin
            tick();
            check_val("os_tmr", 32'(tmr[1]), (k >= kw) ? 1 : 0);
        end
        peek(1, 1, d); check_val("os_status", 32'(d), 32'h05);
        peek(1, 0, d); check_val("os_ctrl", 32'(d), 32'h02);
        peek(1, 4, d); check_val("os_cnt", 32'(d), 0);
        check_val("os_irq", 32'(irq), 0);

        // PWM duty on ch2, TOP = 9
        cmp_tab = '{3, 3, 0, 0, 12};
        inv_tab = '{0, 1, 0, 0, 0};
        cmp_tab[3] = $urandom_range(0, 12);
        inv_tab[3] = $urandom_range(0, 1);
        wr(2, 8, 9);
        wr(2, 9, 0);
        for (int w = 0; w < 5; w++) begin
            wr(2, 12, cmp_tab[w]);
            wr(2, 13, 0);
            wr(2, 0, 32'h05 | (inv_tab[w] << 5));
            hi = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                hi += int'(tmr[2]);
            end
            lo = 2 * ((cmp_tab[w] < 10) ? cmp_tab[w] : 10);
            check_val($sformatf("pwm_high_cmp%0d_inv%0d", cmp_tab[w], inv_tab[w]),
                      32'(hi), (inv_tab[w] != 0) ? 20 - lo : lo);
        end

        // External clock on ch3
        wr(3, 0, 32'h09);
        for (int p = 0; p < 5; p++) begin
            hi = $urandom_range(3, 5);
            lo = $urandom_range(2, 4);
            ext[3] = 1'b1;
            tick();
            tick();
            peek(3, 4, d); check_val("ext_before", 32'(d), p);
            tick();
            peek(3, 4, d); check_val("ext_after", 32'(d), p + 1);
            repeat (hi - 3) tick();
            ext[3] = 1'b0;
            repeat (lo) tick();
            peek(3, 4, d); check_val("ext_held_high", 32'(d), p + 1);
        end
        rd_re(3, 4, d); check_val("ext_final_lo", 32'(d), 5);
        peek(3, 5, d);  check_val("ext_final_hi", 32'(d), 0);

        // Atomic writes and tear-free reads on ch0
        wr(0, 0, 0);
        wr(0, 2, 0);
        wr(0, 3, 0);
        wr(0, 8, 32'hFF);
        wr(0, 9, 32'hFF);
        wr(0, 4, 32'hFF);
        peek(0, 4, d);  check_val("atom_lo_staged", 32'(d), held);
        wr(0, 5, 0);
        peek(0, 4, d);  check_val("atom_commit_lo", 32'(d), 32'hFF);
        wr(0, 0, 32'h01);
        rd_re(0, 4, d); check_val("tear_lo", 32'(d), 32'hFF);
        tick();
        tick();
        tick();
        peek(0, 5, d);  check_val("tear_hi_snap", 32'(d), 0);
        rd_re(0, 4, d); check_val("tear_live_lo", 32'(d), 32'h03);
        peek(0, 5, d);  check_val("tear_hi_new", 32'(d), 32'h01);

        // CNT commit colliding with a running step
        cnt_hi = $urandom_range(1, 255);
        wr(0, 4, 32'h34);
        wr(0, 5, cnt_hi);
        rd_re(0, 4, d); check_val("coll_cnt_lo", 32'(d), 32'h34);
        peek(0, 5, d);  check_val("coll_cnt_hi", 32'(d), cnt_hi);

        // FLAG W1C in the same cycle as a wrap
        wr(0, 0, 0);
        wr(0, 8, 3);
        wr(0, 9, 0);
        wr(0, 4, 0);
        wr(0, 5, 0);
        wr(0, 1, 1);
        peek(0, 1, d);  check_val("coll_flag_pre", 32'(d[0]), 0);
        wr(0, 0, 32'h01);
        tick();
        tick();
        tick();
        wr(0, 1, 1);
        peek(0, 1, d);  check_val("coll_flag_set_wins", 32'(d[0]), 1);
        wr(0, 1, 1);
        peek(0, 1, d);  check_val("w1c_plain", 32'(d[0]), 0);

        // Reset mid-PWM
        check_val("pre_rst_tmr2", 32'(tmr[2]), 1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_tmr", 32'(tmr), 0);
        check_val("mid_rst_irq", 32'(irq), 0);
        check_val("mid_rst_irqvec", 32'(irq_vec), 0);
        peek(2, 8, d); check_val("mid_rst_top_lo", 32'(d), 32'hFF);
        peek(2, 9, d); check_val("mid_rst_top_hi", 32'(d), 32'hFF);
        peek(2, 0, d); check_val("mid_rst_ctrl", 32'(d), 0);
        peek(3, 4, d); check_val("mid_rst_cnt", 32'(d), 0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
